// File: rtl/bus_xfer_ctrl.sv
// Bus-side initiator for the register slots on the shared tri-state data bus.
// Sequences output-enable, load/clear and release strobes for one command at a time.
module bus_xfer_ctrl #(
    parameter int unsigned N_REG = 8,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_src,
    input  logic [2:0]       req_dst,
    input  logic             req_clr,
    output logic [N_REG-1:0] out_en,
    output logic [N_REG-1:0] load,
    output logic [N_REG-1:0] clr,
    input  logic [WIDTH-1:0] bus_in,
    output logic [WIDTH-1:0] last_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned IDX_W = 3;
    localparam logic [IDX_W:0] N_REG_L = (IDX_W + 1)'(N_REG);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        LATCH   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   src_q;
    logic [IDX_W-1:0]   dst_q;
    logic               clr_q;
    logic [N_REG-1:0]   out_en_nxt;
    logic [N_REG-1:0]   load_nxt;
    logic [N_REG-1:0]   clr_nxt;
    logic               done_nxt;
    logic               err_nxt;
    logic               accept;
    logic               bad_cmd;

    // A clear never drives the bus, so its source index is irrelevant.
    always_comb begin
        bad_cmd = ({1'b0, req_dst} >= N_REG_L)
               || (!req_clr && (({1'b0, req_src} >= N_REG_L) || (req_src == req_dst)));
    end

    // Next state and next strobe values; every output is registered below.
    always_comb begin
        state_nxt  = state;
        out_en_nxt = '0;
        load_nxt   = '0;
        clr_nxt    = '0;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    if (bad_cmd) begin
                        err_nxt = 1'b1;
                    end else begin
                        accept = 1'b1;
                        if (req_clr) begin
                            state_nxt = LATCH;
                            clr_nxt   = N_REG'(1) << req_dst;
                        end else begin
                            state_nxt  = DRIVE;
                            out_en_nxt = N_REG'(1) << req_src;
                        end
                    end
                end
            end
            DRIVE: begin
                state_nxt  = LATCH;
                out_en_nxt = N_REG'(1) << src_q;
                load_nxt   = N_REG'(1) << dst_q;
            end
            LATCH: begin
                state_nxt = RELEASE;
                done_nxt  = 1'b1;
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            clr_q     <= 1'b0;
            out_en    <= '0;
            load      <= '0;
            clr       <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            last_data <= '0;
        end else begin
            state     <= state_nxt;
            out_en    <= out_en_nxt;
            load      <= load_nxt;
            clr       <= clr_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            busy      <= (state_nxt != IDLE);
            req_ready <= (state_nxt == IDLE);
            if (accept) begin
                src_q <= req_src;
                dst_q <= req_dst;
                clr_q <= req_clr;
            end
            // Bus is only trusted while the destination load is asserted.
            if (state == LATCH && !clr_q) begin
                last_data <= bus_in;
            end
        end
    end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed and random-stream bench for bus_xfer_ctrl (N_REG=8 main instance,
// N_REG=4 instance for the slot-range reject).
module tb_bus_xfer_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       req_valid, req_ready, req_clr;
    logic [2:0] req_src, req_dst;
    logic [7:0] out_en, load, clr, bus_in, last_data;
    logic       busy, done, err;

    logic       req_valid4, req_ready4, req_clr4;
    logic [2:0] req_src4, req_dst4;
    logic [3:0] out_en4, load4, clr4;
    logic [7:0] last_data4;
    logic       busy4, done4, err4;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    bus_xfer_ctrl #(.N_REG(8), .WIDTH(8)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_clr(req_clr),
        .out_en(out_en), .load(load), .clr(clr), .bus_in(bus_in),
        .last_data(last_data), .busy(busy), .done(done), .err(err)
    );

    bus_xfer_ctrl #(.N_REG(4), .WIDTH(8)) dut4 (
        .clk(clk), .reset(reset), .req_valid(req_valid4), .req_ready(req_ready4),
        .req_src(req_src4), .req_dst(req_dst4), .req_clr(req_clr4),
        .out_en(out_en4), .load(load4), .clr(clr4), .bus_in(bus_in),
        .last_data(last_data4), .busy(busy4), .done(done4), .err(err4)
    );

    // Every-cycle invariants on the main instance, plus done/err pulse counting.
    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            if ($countones(out_en) > 1) begin errors++; $display("FAIL inv_oe_onehot got=%h", out_en); end
            checks++;
            if ($countones(load | clr) > 1) begin errors++; $display("FAIL inv_ld_onehot load=%h clr=%h", load, clr); end
            checks++;
            if ((load & out_en) !== 8'h00) begin errors++; $display("FAIL inv_self_drive load=%h oe=%h", load, out_en); end
            checks++;
            if (!busy && (out_en | load | clr) !== 8'h00) begin
                errors++; $display("FAIL inv_idle_strobe oe=%h load=%h clr=%h", out_en, load, clr);
            end
            checks++;
            if (done && err) begin errors++; $display("FAIL inv_done_err got both high exp not both"); end
            if (done === 1'b1) done_cnt++;
            if (err === 1'b1) err_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [2:0] s, input logic [2:0] d, input logic c);
        req_valid = 1'b1;
        req_src   = s;
        req_dst   = d;
        req_clr   = c;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        checks++; if (out_en !== 8'h00 || load !== 8'h00 || clr !== 8'h00) begin
            errors++; $display("FAIL rst_strobes got=%h/%h/%h exp=00/00/00", out_en, load, clr); end
        checks++; if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_ready_busy got=%b/%b exp=1/0", req_ready, busy); end
        checks++; if (last_data !== 8'h00 || done !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL rst_data got=%h done=%b err=%b exp=00/0/0", last_data, done, err); end
    endtask

    task automatic test_transfer();
        cmd(3'd0, 3'd1, 1'b0);
        tick();
        req_valid = 1'b0;
        bus_in = 8'hxx;
        checks++; if (out_en !== 8'h01 || load !== 8'h00) begin
            errors++; $display("FAIL xfer_drive got oe=%h load=%h exp=01/00", out_en, load); end
        checks++; if (req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL xfer_ready1 got=%b/%b exp=0/1", req_ready, busy); end
        tick();
        bus_in = 8'hA5;
        checks++; if (out_en !== 8'h01 || load !== 8'h02) begin
            errors++; $display("FAIL xfer_latch got oe=%h load=%h exp=01/02", out_en, load); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL xfer_ready2 got=%b exp=0", req_ready); end
        tick();
        bus_in = 8'hxx;
        checks++; if (done !== 1'b1 || out_en !== 8'h00 || load !== 8'h00) begin
            errors++; $display("FAIL xfer_release got done=%b oe=%h load=%h exp=1/00/00", done, out_en, load); end
        checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL xfer_data got=%h exp=a5", last_data); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL xfer_ready3 got=%b exp=0", req_ready); end
        tick();
        checks++; if (req_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL xfer_idle got ready=%b done=%b busy=%b exp=1/0/0", req_ready, done, busy); end
    endtask

    task automatic test_clear();
        cmd(3'd0, 3'd0, 1'b1);
        tick();
        req_valid = 1'b0;
        checks++; if (clr !== 8'h01 || out_en !== 8'h00 || load !== 8'h00 || done !== 1'b0) begin
            errors++; $display("FAIL clr_latch got clr=%h oe=%h load=%h done=%b exp=01/00/00/0", clr, out_en, load, done); end
        tick();
        checks++; if (done !== 1'b1 || clr !== 8'h00) begin
            errors++; $display("FAIL clr_done got done=%b clr=%h exp=1/00", done, clr); end
        checks++; if (last_data !== 8'hA5) begin errors++; $display("FAIL clr_data got=%h exp=a5", last_data); end
        tick();
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL clr_idle got=%b exp=1", req_ready); end
    endtask

    task automatic test_back_to_back();
        cmd(3'd2, 3'd3, 1'b0);
        tick();
        cmd(3'd3, 3'd0, 1'b0);
        checks++; if (out_en !== 8'h04) begin errors++; $display("FAIL b2b_drive1 got=%h exp=04", out_en); end
        tick();
        bus_in = 8'h3C;
        checks++; if (load !== 8'h08 || out_en !== 8'h04) begin
            errors++; $display("FAIL b2b_latch1 got oe=%h load=%h exp=04/08", out_en, load); end
        tick();
        checks++; if (done !== 1'b1 || out_en !== 8'h00 || last_data !== 8'h3C) begin
            errors++; $display("FAIL b2b_done1 got done=%b oe=%h data=%h exp=1/00/3c", done, out_en, last_data); end
        tick();
        checks++; if (req_ready !== 1'b1 || out_en !== 8'h00) begin
            errors++; $display("FAIL b2b_gap got ready=%b oe=%h exp=1/00", req_ready, out_en); end
        tick();
        req_valid = 1'b0;
        checks++; if (out_en !== 8'h08 || req_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_drive2 got oe=%h ready=%b exp=08/0", out_en, req_ready); end
        tick();
        bus_in = 8'hC3;
        checks++; if (load !== 8'h01 || out_en !== 8'h08) begin
            errors++; $display("FAIL b2b_latch2 got oe=%h load=%h exp=08/01", out_en, load); end
        tick();
        checks++; if (done !== 1'b1 || last_data !== 8'hC3) begin
            errors++; $display("FAIL b2b_done2 got done=%b data=%h exp=1/c3", done, last_data); end
        tick();
    endtask

    task automatic test_reject();
        cmd(3'd4, 3'd4, 1'b0);
        tick();
        req_valid = 1'b0;
        checks++; if (err !== 1'b1 || busy !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL rej_same got err=%b busy=%b ready=%b exp=1/0/1", err, busy, req_ready); end
        checks++; if ((out_en | load | clr) !== 8'h00) begin
            errors++; $display("FAIL rej_strobes got=%h exp=00", out_en | load | clr); end
        tick();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rej_pulse got=%b exp=0", err); end

        req_valid4 = 1'b1; req_src4 = 3'd0; req_dst4 = 3'd5; req_clr4 = 1'b0;
        tick();
        req_valid4 = 1'b0;
        checks++; if (err4 !== 1'b1 || busy4 !== 1'b0 || (out_en4 | load4 | clr4) !== 4'h0) begin
            errors++; $display("FAIL rej_range4 got err=%b busy=%b strobes=%h exp=1/0/0", err4, busy4, out_en4 | load4 | clr4); end

        cmd(3'd2, 3'd2, 1'b1);
        tick();
        req_valid = 1'b0;
        checks++; if (err !== 1'b0 || clr !== 8'h04) begin
            errors++; $display("FAIL rej_clr_ok got err=%b clr=%h exp=0/04", err, clr); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid();
        cmd(3'd1, 3'd2, 1'b0);
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (load !== 8'h04 || out_en !== 8'h02) begin
            errors++; $display("FAIL rmid_latch got oe=%h load=%h exp=02/04", out_en, load); end
        reset = 1'b1;
        bus_in = 8'h77;
        tick();
        checks++; if ((out_en | load | clr) !== 8'h00 || done !== 1'b0) begin
            errors++; $display("FAIL rmid_strobes got=%h done=%b exp=00/0", out_en | load | clr, done); end
        checks++; if (last_data !== 8'h00) begin errors++; $display("FAIL rmid_data got=%h exp=00", last_data); end
        reset = 1'b0;
        tick();
        checks++; if (req_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0 || last_data !== 8'h00) begin
            errors++; $display("FAIL rmid_after got ready=%b done=%b busy=%b data=%h exp=1/0/0/00", req_ready, done, busy, last_data); end
    endtask

    task automatic test_random();
        int exp_ok;
        int exp_rej;
        exp_ok = 0;
        exp_rej = 0;
        done_cnt = 0;
        err_cnt = 0;
        for (int n = 0; n < 1000; n++) begin
            logic [2:0] s;
            logic [2:0] d;
            logic       c;
            int         w;
            w = 0;
            while (req_ready !== 1'b1 && w < 10) begin tick(); w++; end
            checks++; if (req_ready !== 1'b1) begin
                errors++; $display("FAIL rand_ready_timeout cmd=%0d got=%b exp=1", n, req_ready); end
            s = 3'($urandom_range(0, 7));
            d = 3'($urandom_range(0, 7));
            c = 1'($urandom_range(0, 1));
            if (c || s != d) exp_ok++; else exp_rej++;
            cmd(s, d, c);
            bus_in = 8'($urandom);
            tick();
            req_valid = 1'b0;
            bus_in = 8'($urandom);
            repeat ($urandom_range(0, 2)) tick();
        end
        repeat (6) tick();
        checks++; if (done_cnt != exp_ok) begin errors++; $display("FAIL rand_done_count got=%0d exp=%0d", done_cnt, exp_ok); end
        checks++; if (err_cnt != exp_rej) begin errors++; $display("FAIL rand_err_count got=%0d exp=%0d", err_cnt, exp_rej); end
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_src = 3'd0; req_dst = 3'd0; req_clr = 1'b0;
        req_valid4 = 1'b0; req_src4 = 3'd0; req_dst4 = 3'd0; req_clr4 = 1'b0;
        bus_in = 8'h00;
        test_reset();
        test_transfer();
        test_clear();
        test_back_to_back();
        test_reject();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_xfer_ctrl.md
Name: bus_xfer_ctrl

Overview:
Bus-side initiator for the register slots on the shared 8-bit tri-state data bus, such as the accumulator, B, output and memory-data registers. It accepts one transfer command at a time over a valid/ready handshake. It then sequences the strobes: the source slot's output enable, then the destination slot's load, then release. The bus value is captured for debug and a completion pulse is issued. It sits between the control/decode logic and the register file, and guarantees at most one bus driver and break-before-make between transfers.

Parameters:
N_REG, 8, number of register slots on the bus (2..8); slot index width is fixed at 3 bits
WIDTH, 8, bus data width

Ports:
clk  input  1  rising-edge clock
reset  input  1  reset, synchronous, active-high
req_valid  input  1  command present
req_ready  output  1  controller can accept a command (high only in IDLE)
req_src  input  3  source slot index
req_dst  input  3  destination slot index
req_clr  input  1  1 = clear dst (no source, no bus drive); 0 = bus transfer src->dst
out_en  output  N_REG  one-hot output-enable per slot (drives bus)
load  output  N_REG  one-hot load strobe per slot
clr  output  N_REG  one-hot clear strobe per slot
bus_in  input  WIDTH  bus value as seen by the controller
last_data  output  WIDTH  bus value sampled on the most recent completed transfer
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when a command completes
err  output  1  one-cycle pulse when a command is rejected

Behaviour:
- Reset (sync, dominant over all other inputs): state=IDLE, out_en=0, load=0, clr=0, last_data=0, done=0, err=0, busy=0, req_ready=1 on the following cycle.
- All outputs are registered; no combinational path from req_* to strobes.
- FSM states: IDLE, DRIVE, LATCH, RELEASE.
- IDLE: req_ready=1. Accept on req_valid&&req_ready at edge T0.
  - Reject with err=1 in cycle T0+1, stay in IDLE, no strobes, if any of these hold: req_dst>=N_REG; or (!req_clr and (req_src>=N_REG or req_src==req_dst)).
  - Valid transfer -> DRIVE. Valid clear -> LATCH with clear flag set.
  - src/dst/clr flag are latched at accept; req_* are ignored while busy.
- DRIVE (cycle T0+1): out_en[src]=1, all loads 0. Gives the bus one settle cycle.
- LATCH (cycle T0+2):
  - Transfer: out_en[src]=1 and load[dst]=1. last_data<=bus_in at the end of this cycle.
  - Clear: clr[dst]=1, out_en=0, load=0, last_data unchanged.
- RELEASE (transfer T0+3, clear T0+2): all strobes 0 and done=1, then IDLE. A new command can be accepted in the cycle after RELEASE.
- Transfer latency is accept-to-done 3 cycles; throughput is one transfer per 4 cycles. Clear latency is 2 cycles; throughput is one clear per 3 cycles.
- Invariants, checked every cycle:
  - popcount(out_en)<=1
  - popcount(load|clr)<=1
  - load[i] and out_en[i] are never both high
  - strobes are never high in IDLE
- done and err never assert in the same cycle. busy=(state!=IDLE).
- Reset mid-operation, in any state: all strobes are low from the next edge. Any in-flight load is abandoned with no done pulse, and last_data returns to 0.
- bus_in containing X/Z outside LATCH is ignored.

Test Plan:
- Reset, then transfer src=0, dst=1 with bus_in=8'hA5 during LATCH:
  - out_en=8'h01 at T0+1 and T0+2; load=8'h02 at T0+2; done at T0+3; last_data=8'hA5.
  - req_ready is low for T0+1..T0+3.
- Clear dst=0: clr=8'h01 for one cycle at T0+1, done at T0+2, out_en and load stay 0, last_data unchanged.
- Back-to-back with req_valid held high for transfers 2->3 (bus 8'h3C) then 3->0 (bus 8'hC3):
  - Second accept occurs in the cycle after the first done.
  - At least one cycle with out_en=0 separates them.
  - last_data ends at 8'hC3.
- Rejects:
  - src=4, dst=4 gives err pulse at T0+1, no strobes, busy=0.
  - With N_REG=4, dst=5 gives err.
  - Clear with src=dst=2 is accepted.
- Assert reset during LATCH of transfer 1->2: all strobes 0 the next cycle, no done, last_data=0, then req_ready=1.
- Random command stream of 1000 commands: one-hot and no-self-drive invariants hold every cycle, and the done count equals the count of valid accepted commands.
